// File: rtl/cpu_seq_pkg.sv
// Shared types and constants for the Master CPU fetch/execute sequencer.
// Holds the controller state encoding, instruction field positions and halt marker.
package cpu_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        EXECUTE,
        MEM,
        WRITEBACK,
        HALT,
        STEP_WAIT
    } seq_state_t;

    // Instruction word layout seen by the decode cluster
    localparam int COND_HI   = 31;
    localparam int COND_LO   = 28;
    localparam int OPCODE_HI = 27;
    localparam int OPCODE_LO = 24;
    localparam int S_BIT     = 23;
    localparam int DEST_HI   = 22;
    localparam int DEST_LO   = 19;
    localparam int SRC2_HI   = 18;
    localparam int SRC2_LO   = 15;
    localparam int SRC1_HI   = 14;
    localparam int SRC1_LO   = 11;
    localparam int SHFT_HI   = 10;
    localparam int SHFT_LO   = 6;
    localparam int MOV_HI    = 18;
    localparam int MOV_LO    = 3;

    localparam logic [31:0] HALT_INSTR       = 32'h0000_0000;
    localparam int          DEFAULT_PROG_LEN = 16;

    function automatic logic set_flags(input logic [31:0] instr);
        return instr[S_BIT];
    endfunction

endpackage

// File: rtl/cpu_sequencer.sv
// Fetch/decode/execute/mem/writeback controller owning PC, instruction and flag registers.
// Latency: 4 cycles per ALU instruction, 5 for LDR/STR; all outputs registered.
// No backpressure: runs free once started; `CPU_SEQ_SINGLE_STEP_EN adds Step-gated execution.
module cpu_sequencer
    import cpu_seq_pkg::*;
#(
    parameter int PC_W     = 8,
    parameter int PROG_LEN = DEFAULT_PROG_LEN,
    parameter int ADDR_W   = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
`ifdef CPU_SEQ_SINGLE_STEP_EN
    input  logic              Step,
`endif
    input  logic [31:0]       Instr_in,
    input  logic              Memory_enable,
    input  logic [ADDR_W-1:0] Mem_addr,
    input  logic              Mem_rw,
    input  logic [31:0]       Mem_wdata,
    input  logic [3:0]        New_flag,
    output logic [31:0]       Instr,
    output logic [PC_W-1:0]   Pc,
    output logic              Enable_i,
    output logic              RW_ram_i,
    output logic [ADDR_W-1:0] Address_in_i,
    output logic              Enable,
    output logic              RW_ram,
    output logic [ADDR_W-1:0] Address_in,
    output logic [31:0]       DataIn,
    output logic [3:0]        Flag,
    output logic              Reg_we,
    output logic              Busy,
    output logic              Done
);

    seq_state_t        state, state_nxt;
    logic [PC_W-1:0]   pc_nxt;
    logic [31:0]       instr_nxt;
    logic [3:0]        flag_nxt;
    logic              en_i_nxt, rw_i_nxt, en_nxt, rw_nxt, we_nxt, busy_nxt, done_nxt;
    logic [ADDR_W-1:0] addr_i_nxt, addr_nxt;
    logic [31:0]       din_nxt;
    logic [PC_W-1:0]   pc_inc;
    logic              last_pc;
    logic              step_go;

    assign pc_inc  = Pc + PC_W'(1);
    // Compared at 32 bits so PROG_LEN == 2**PC_W still halts on the top address
    assign last_pc = (32'(Pc) == 32'(PROG_LEN - 1));

`ifdef CPU_SEQ_SINGLE_STEP_EN
    logic step_q;
    assign step_go = Step && !step_q;
`else
    assign step_go = 1'b0;
`endif

    always_comb begin
        state_nxt  = state;
        pc_nxt     = Pc;
        instr_nxt  = Instr;
        flag_nxt   = Flag;
        en_i_nxt   = 1'b0;
        rw_i_nxt   = 1'b1;
        addr_i_nxt = Address_in_i;
        en_nxt     = 1'b0;
        rw_nxt     = 1'b1;
        addr_nxt   = Address_in;
        din_nxt    = DataIn;
        we_nxt     = 1'b0;
        busy_nxt   = Busy;
        done_nxt   = Done;

        case (state)
            IDLE: begin
                if (Start) begin
                    state_nxt  = FETCH;
                    pc_nxt     = '0;
                    busy_nxt   = 1'b1;
                    done_nxt   = 1'b0;
                    en_i_nxt   = 1'b1;
                    addr_i_nxt = '0;
                end
            end
            FETCH: begin
                state_nxt = DECODE;
            end
            DECODE: begin
                instr_nxt = Instr_in;
                state_nxt = EXECUTE;
            end
            EXECUTE: begin
                if (set_flags(Instr)) begin
                    flag_nxt = New_flag;
                end
                if (Memory_enable) begin
                    state_nxt = MEM;
                    en_nxt    = 1'b1;
                    rw_nxt    = Mem_rw;
                    addr_nxt  = Mem_addr;
                    din_nxt   = Mem_wdata;
                end else begin
                    state_nxt = WRITEBACK;
                    we_nxt    = 1'b1;
                end
            end
            MEM: begin
                state_nxt = WRITEBACK;
                // A store writes memory, not the register bank
                we_nxt    = !(Memory_enable && !Mem_rw);
            end
            WRITEBACK: begin
                if (last_pc || (Instr == HALT_INSTR)) begin
                    state_nxt = HALT;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                end else begin
                    pc_nxt = pc_inc;
`ifdef CPU_SEQ_SINGLE_STEP_EN
                    state_nxt = STEP_WAIT;
`else
                    state_nxt  = FETCH;
                    en_i_nxt   = 1'b1;
                    addr_i_nxt = ADDR_W'(pc_inc);
`endif
                end
            end
            HALT: begin
                if (!Start) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b0;
                end
            end
            STEP_WAIT: begin
                if (step_go) begin
                    state_nxt  = FETCH;
                    en_i_nxt   = 1'b1;
                    addr_i_nxt = ADDR_W'(Pc);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state        <= IDLE;
            Pc           <= '0;
            Instr        <= '0;
            Flag         <= '0;
            Enable_i     <= 1'b0;
            RW_ram_i     <= 1'b1;
            Address_in_i <= '0;
            Enable       <= 1'b0;
            RW_ram       <= 1'b1;
            Address_in   <= '0;
            DataIn       <= '0;
            Reg_we       <= 1'b0;
            Busy         <= 1'b0;
            Done         <= 1'b0;
`ifdef CPU_SEQ_SINGLE_STEP_EN
            step_q       <= 1'b0;
`endif
        end else begin
            state        <= state_nxt;
            Pc           <= pc_nxt;
            Instr        <= instr_nxt;
            Flag         <= flag_nxt;
            Enable_i     <= en_i_nxt;
            RW_ram_i     <= rw_i_nxt;
            Address_in_i <= addr_i_nxt;
            Enable       <= en_nxt;
            RW_ram       <= rw_nxt;
            Address_in   <= addr_nxt;
            DataIn       <= din_nxt;
            Reg_we       <= we_nxt;
            Busy         <= busy_nxt;
            Done         <= done_nxt;
`ifdef CPU_SEQ_SINGLE_STEP_EN
            step_q       <= Step;
`endif
        end
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: instruction RAM model plus hand-timed cycle checks.
module tb_cpu_sequencer;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Start;
`ifdef CPU_SEQ_SINGLE_STEP_EN
    logic        Step;
`endif
    logic [31:0] Instr_in = '0;
    logic        Memory_enable;
    logic [15:0] Mem_addr;
    logic        Mem_rw;
    logic [31:0] Mem_wdata;
    logic [3:0]  New_flag;
    logic [31:0] Instr;
    logic [7:0]  Pc;
    logic        Enable_i, RW_ram_i, Enable, RW_ram, Reg_we, Busy, Done;
    logic [15:0] Address_in_i, Address_in;
    logic [31:0] DataIn;
    logic [3:0]  Flag;

    logic [31:0] imem [16];
    int checks = 0;
    int errors = 0;

    cpu_sequencer #(.PC_W(8), .PROG_LEN(16), .ADDR_W(16)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start),
`ifdef CPU_SEQ_SINGLE_STEP_EN
        .Step(Step),
`endif
        .Instr_in(Instr_in), .Memory_enable(Memory_enable), .Mem_addr(Mem_addr),
        .Mem_rw(Mem_rw), .Mem_wdata(Mem_wdata), .New_flag(New_flag),
        .Instr(Instr), .Pc(Pc), .Enable_i(Enable_i), .RW_ram_i(RW_ram_i),
        .Address_in_i(Address_in_i), .Enable(Enable), .RW_ram(RW_ram),
        .Address_in(Address_in), .DataIn(DataIn), .Flag(Flag), .Reg_we(Reg_we),
        .Busy(Busy), .Done(Done)
    );

    always #5 Clk = ~Clk;

    // Synchronous instruction RAM: data appears the cycle after the fetch
    always @(posedge Clk) begin
        if (Enable_i && RW_ram_i) Instr_in <= imem[Address_in_i[3:0]];
    end

    // memory_control stand-in: opcode 5 is a memory instruction
    assign Memory_enable = (Instr[27:24] == 4'h5);

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b0;
        Start = 1'b0;
`ifdef CPU_SEQ_SINGLE_STEP_EN
        Step = 1'b0;
`endif
        New_flag = 4'h0;
        Mem_addr = 16'h0;
        Mem_rw = 1'b1;
        Mem_wdata = 32'h0;
        tick();
        tick();
        Reset = 1'b1;
        tick();
    endtask

    task automatic load_alu16();
        for (int i = 0; i < 16; i++) imem[i] = 32'hE100_0000 | 32'(i + 1);
    endtask

    task automatic clear_imem();
        for (int i = 0; i < 16; i++) imem[i] = 32'h0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({Pc, Instr, Flag} !== {8'h0, 32'h0, 4'h0}) begin
            errors++;
            $display("FAIL reset_regs got pc=%h instr=%h flag=%h want 0", Pc, Instr, Flag);
        end
        checks++;
        if ({Enable_i, Enable, Reg_we, Busy, Done} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl got en_i=%b en=%b we=%b busy=%b done=%b want 0",
                     Enable_i, Enable, Reg_we, Busy, Done);
        end
        checks++;
        if ({RW_ram_i, RW_ram, Address_in_i, Address_in, DataIn} !== {2'b11, 16'h0, 16'h0, 32'h0}) begin
            errors++;
            $display("FAIL reset_ram got rw_i=%b rw=%b ai=%h a=%h d=%h want 1 1 0 0 0",
                     RW_ram_i, RW_ram, Address_in_i, Address_in, DataIn);
        end
    endtask

    task automatic test_alu_program();
        do_reset();
        clear_imem();
        imem[0] = 32'hE100_0011;
        imem[1] = 32'hE200_0022;
        imem[2] = 32'hE300_0033;
        Start = 1'b1;
        for (int c = 1; c <= 18; c++) begin
            tick();
            if (c == 6) Start = 1'b0;
            if (c == 7) Start = 1'b1;
            if (c <= 15) begin
                checks++;
                if (Reg_we !== ((c % 4) == 0)) begin
                    errors++;
                    $display("FAIL alu_reg_we cycle %0d got %b want %b", c, Reg_we, (c % 4) == 0);
                end
            end
            if (c <= 16) begin
                checks++;
                if (Busy !== 1'b1 || Done !== 1'b0) begin
                    errors++;
                    $display("FAIL alu_busy cycle %0d got busy=%b done=%b want 1 0", c, Busy, Done);
                end
            end
            if (c >= 17) begin
                checks++;
                if ({Done, Busy, Pc} !== {1'b1, 1'b0, 8'd3}) begin
                    errors++;
                    $display("FAIL alu_halt cycle %0d got done=%b busy=%b pc=%0d want 1 0 3",
                             c, Done, Busy, Pc);
                end
            end
        end
        Start = 1'b0;
        tick();
        checks++;
        if (Done !== 1'b0) begin
            errors++;
            $display("FAIL alu_idle_done got %b want 0", Done);
        end
    endtask

    task automatic test_store();
        do_reset();
        clear_imem();
        imem[0] = 32'hE100_0001;
        imem[1] = 32'hE100_0002;
        imem[2] = 32'hE500_0002;
        Mem_addr = 16'h0004;
        Mem_wdata = 32'h0000_AAA2;
        Mem_rw = 1'b0;
        Start = 1'b1;
        for (int c = 1; c <= 18; c++) begin
            tick();
            if (c == 8) begin
                checks++;
                if (Reg_we !== 1'b1) begin
                    errors++;
                    $display("FAIL st_alu_we got %b want 1", Reg_we);
                end
            end
            if (c == 11) begin
                checks++;
                if (Enable !== 1'b0) begin
                    errors++;
                    $display("FAIL st_exec_en got %b want 0", Enable);
                end
            end
            if (c == 12) begin
                checks++;
                if ({Enable, RW_ram, Address_in, DataIn, Reg_we} !== {1'b1, 1'b0, 16'h0004, 32'h0000_AAA2, 1'b0}) begin
                    errors++;
                    $display("FAIL st_mem got en=%b rw=%b a=%h d=%h we=%b want 1 0 0004 0000aaa2 0",
                             Enable, RW_ram, Address_in, DataIn, Reg_we);
                end
            end
            if (c == 13) begin
                checks++;
                if ({Reg_we, Enable, RW_ram} !== 3'b001) begin
                    errors++;
                    $display("FAIL st_wb got we=%b en=%b rw=%b want 0 0 1", Reg_we, Enable, RW_ram);
                end
            end
            if (c == 14) begin
                checks++;
                if ({Enable_i, Address_in_i} !== {1'b1, 16'd3}) begin
                    errors++;
                    $display("FAIL st_next_fetch got en_i=%b ai=%0d want 1 3", Enable_i, Address_in_i);
                end
            end
            if (c == 18) begin
                checks++;
                if ({Done, Pc} !== {1'b1, 8'd3}) begin
                    errors++;
                    $display("FAIL st_halt got done=%b pc=%0d want 1 3", Done, Pc);
                end
            end
        end
    endtask

    task automatic test_flags();
        do_reset();
        clear_imem();
        imem[0] = 32'h0180_0001;
        imem[1] = 32'h0100_0002;
        New_flag = 4'b0100;
        Start = 1'b1;
        for (int c = 1; c <= 13; c++) begin
            tick();
            if (c == 3) begin
                checks++;
                if (Flag !== 4'b0000) begin
                    errors++;
                    $display("FAIL flag_early got %b want 0000", Flag);
                end
            end
            if (c == 4) begin
                New_flag = 4'b1111;
                checks++;
                if (Flag !== 4'b0100) begin
                    errors++;
                    $display("FAIL flag_set got %b want 0100", Flag);
                end
            end
            if (c == 8 || c == 13) begin
                checks++;
                if (Flag !== 4'b0100) begin
                    errors++;
                    $display("FAIL flag_hold cycle %0d got %b want 0100", c, Flag);
                end
            end
        end
        checks++;
        if (Done !== 1'b1) begin
            errors++;
            $display("FAIL flag_done got %b want 1", Done);
        end
    endtask

    task automatic test_prog_len();
        int max_pc = 0;
        int we_cnt = 0;
        int c = 0;
        do_reset();
        load_alu16();
        Start = 1'b1;
        while (Done !== 1'b1 && c < 80) begin
            tick();
            c++;
            if (int'(Pc) > max_pc) max_pc = int'(Pc);
            if (Reg_we === 1'b1) we_cnt++;
            if (c == 61) begin
                checks++;
                if ({Enable_i, Address_in_i} !== {1'b1, 16'd15}) begin
                    errors++;
                    $display("FAIL len_fetch15 got en_i=%b ai=%0d want 1 15", Enable_i, Address_in_i);
                end
            end
        end
        checks++;
        if (c != 65) begin
            errors++;
            $display("FAIL len_done_cycle got %0d want 65", c);
        end
        checks++;
        if ({Pc, 8'(max_pc)} !== {8'd15, 8'd15}) begin
            errors++;
            $display("FAIL len_pc got pc=%0d max=%0d want 15 15", Pc, max_pc);
        end
        checks++;
        if (we_cnt != 16) begin
            errors++;
            $display("FAIL len_we_count got %0d want 16", we_cnt);
        end
    endtask

    task automatic test_reset_mid_execute();
        do_reset();
        load_alu16();
        for (int i = 0; i < 16; i++) imem[i] = imem[i] | 32'h0080_0000;
        New_flag = 4'b1010;
        Start = 1'b1;
        for (int c = 1; c <= 23; c++) tick();
        checks++;
        if ({Pc, Flag, Busy} !== {8'd5, 4'b1010, 1'b1}) begin
            errors++;
            $display("FAIL mid_pre got pc=%0d flag=%b busy=%b want 5 1010 1", Pc, Flag, Busy);
        end
        Reset = 1'b0;
        #2;
        checks++;
        if ({Pc, Instr, Flag, Busy} !== {8'd0, 32'h0, 4'h0, 1'b0}) begin
            errors++;
            $display("FAIL mid_regs got pc=%0d instr=%h flag=%b busy=%b want 0 0 0 0", Pc, Instr, Flag, Busy);
        end
        checks++;
        if ({Enable_i, Enable, Reg_we, Done} !== 4'b0) begin
            errors++;
            $display("FAIL mid_ctrl got en_i=%b en=%b we=%b done=%b want 0", Enable_i, Enable, Reg_we, Done);
        end
        Reset = 1'b1;
        Start = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_mem();
        int we_seen = 0;
        do_reset();
        clear_imem();
        imem[0] = 32'hE500_0000;
        Mem_addr = 16'h0010;
        Mem_wdata = 32'h1234_5678;
        Mem_rw = 1'b0;
        Start = 1'b1;
        for (int c = 1; c <= 4; c++) tick();
        checks++;
        if (Enable !== 1'b1) begin
            errors++;
            $display("FAIL mmem_pre got en=%b want 1", Enable);
        end
        Start = 1'b0;
        Reset = 1'b0;
        #2;
        Reset = 1'b1;
        checks++;
        if ({Enable, RW_ram, Address_in, DataIn} !== {1'b0, 1'b1, 16'h0, 32'h0}) begin
            errors++;
            $display("FAIL mmem_abort got en=%b rw=%b a=%h d=%h want 0 1 0 0", Enable, RW_ram, Address_in, DataIn);
        end
        for (int c = 0; c < 4; c++) begin
            tick();
            if (Reg_we === 1'b1 || Busy === 1'b1) we_seen++;
        end
        checks++;
        if (we_seen != 0) begin
            errors++;
            $display("FAIL mmem_after got %0d active cycles want 0", we_seen);
        end
    endtask

`ifdef CPU_SEQ_SINGLE_STEP_EN
    task automatic test_single_step();
        int bad = 0;
        int we_cnt = 0;
        do_reset();
        load_alu16();
        Start = 1'b1;
        for (int c = 1; c <= 5; c++) tick();
        for (int c = 0; c < 20; c++) begin
            if (Pc !== 8'd1 || Busy !== 1'b1 || Reg_we !== 1'b0 || Enable_i !== 1'b0) bad++;
            tick();
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL step_wait got %0d bad cycles want 0", bad);
        end
        Step = 1'b1;
        tick();
        Step = 1'b0;
        for (int c = 0; c < 30; c++) begin
            if (Reg_we === 1'b1) we_cnt++;
            tick();
        end
        checks++;
        if (we_cnt != 1 || Pc !== 8'd2) begin
            errors++;
            $display("FAIL step_one got we=%0d pc=%0d want 1 2", we_cnt, Pc);
        end
    endtask
`endif

    initial begin
        #300000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        clear_imem();
        test_reset();
`ifdef CPU_SEQ_SINGLE_STEP_EN
        test_single_step();
`else
        test_alu_program();
        test_store();
        test_flags();
        test_prog_len();
        test_reset_mid_execute();
        test_reset_mid_mem();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
